prbs_checker: RTL and testbench

Self-synchronising PRBS checker that sits directly downstream of the team's programmable LFSR generator. It consumes the generator's word stream (or the same stream after a link) and predicts each next word from the same polynomial, length and shift configuration. It declares lock after a run of correct predictions and counts bit errors while locked. It is used for link BIST and for verifying the generator itself.

---
 rtl/prbs_pkg.sv | 51 +++++
 rtl/prbs_checker_if.sv | 33 +++
 rtl/prbs_popcount.sv | 17 +
 rtl/prbs_checker.sv | 150 +++++++++++++++
 tb/tb_prbs_checker.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/prbs_pkg.sv
// Shared types, default parameters and the LFSR word-advance function used by the
// PRBS checker.
package prbs_pkg;

    localparam int DEF_WIDTH    = 8;
    localparam int DEF_LOCK_THR = 4;
    localparam int DEF_LOSS_THR = 3;
    localparam int DEF_CNT_W    = 16;

    // Widest word the advance function handles; narrower words are masked down.
    localparam int MAX_W = 64;

    typedef logic [MAX_W-1:0] wide_t;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // Applies 'shift' Fibonacci steps (clamped to 'width') to 'cur'. Each step shifts
    // left and inserts the XOR of the tapped bits 0..len into bit 0.
    function automatic wide_t lfsr_advance(
        input wide_t cur,
        input wide_t poly,
        input wide_t len,
        input wide_t shift,
        input int    width
    );
        wide_t st;
        wide_t mask;
        wide_t steps;
        logic  fb;
        mask = '0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < width) mask[i] = 1'b1;
        end
        steps = (shift > wide_t'(width)) ? wide_t'(width) : shift;
        st    = cur & mask;
        for (int s = 0; s < MAX_W; s++) begin
            if (wide_t'(s) < steps) begin
                fb = 1'b0;
                for (int i = 0; i < MAX_W; i++) begin
                    if ((wide_t'(i) <= len) && (i < width) && poly[i]) fb = fb ^ st[i];
                end
                st = ((st << 1) | wide_t'(fb)) & mask;
            end
        end
        return st;
    endfunction

endpackage

// File: rtl/prbs_checker_if.sv
// Bundle of configuration, data and status signals between the PRBS source side
// and the checker.
interface prbs_checker_if
    import prbs_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) ();

    // EN_I is a valid strobe qualifying DATA_I; the checker is always ready and
    // consumes every qualified word, there is no backpressure.
    logic             LOAD_I;
    logic             EN_I;
    logic [WIDTH-1:0] POLY_I;
    logic [WIDTH-1:0] LEN_I;
    logic [WIDTH-1:0] SHIFT_I;
    logic [WIDTH-1:0] DATA_I;
    logic             LOCK_O;
    logic             ERR_O;
    logic [CNT_W-1:0] ERR_CNT_O;
    state_t           STATE_O;

    modport master (
        output LOAD_I, EN_I, POLY_I, LEN_I, SHIFT_I, DATA_I,
        input  LOCK_O, ERR_O, ERR_CNT_O, STATE_O
    );

    modport slave (
        input  LOAD_I, EN_I, POLY_I, LEN_I, SHIFT_I, DATA_I,
        output LOCK_O, ERR_O, ERR_CNT_O, STATE_O
    );

endinterface

// File: rtl/prbs_popcount.sv
// Combinational population count of a WIDTH-bit vector.
module prbs_popcount #(
    parameter  int WIDTH = 8,
    localparam int OUT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] data_i,
    output logic [OUT_W-1:0] count_o
);

    always_comb begin
        count_o = '0;
        for (int i = 0; i < WIDTH; i++) begin
            count_o = count_o + OUT_W'(data_i[i]);
        end
    end

endmodule

// File: rtl/prbs_checker.sv
// Self-synchronising PRBS checker: seeds from the incoming stream, locks after a run of
// correct predictions, then free-runs its reference and counts bit errors while locked.
module prbs_checker
    import prbs_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int LOCK_THR = DEF_LOCK_THR,
    parameter int LOSS_THR = DEF_LOSS_THR,
    parameter int CNT_W    = DEF_CNT_W
) (
    input logic           CLK_I,
    input logic           RST_I,
    prbs_checker_if.slave bus
);

    localparam int POP_W   = $clog2(WIDTH + 1);
    localparam int MATCH_W = $clog2(LOCK_THR + 1);
    localparam int LOSS_W  = $clog2(LOSS_THR + 1);
    localparam int SUM_W   = CNT_W + 1;

    state_t             state_q, state_d;
    logic               seed_pend_q, seed_pend_d;
    logic [WIDTH-1:0]   ref_q, ref_d;
    logic [MATCH_W-1:0] match_q, match_d;
    logic [LOSS_W-1:0]  loss_q, loss_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic [WIDTH-1:0]   poly_q, poly_d;
    logic [WIDTH-1:0]   len_q, len_d;
    logic [WIDTH-1:0]   shift_q, shift_d;

    logic [WIDTH-1:0]   pred;
    logic [WIDTH-1:0]   diff;
    logic [POP_W-1:0]   pop_cnt;
    logic [SUM_W-1:0]   sum;
    logic [CNT_W-1:0]   cnt_sat;

    assign pred = WIDTH'(lfsr_advance(wide_t'(ref_q), wide_t'(poly_q), wide_t'(len_q),
                                      wide_t'(shift_q), WIDTH));
    assign diff = bus.DATA_I ^ pred;

    prbs_popcount #(
        .WIDTH (WIDTH)
    ) u_popcount (
        .data_i  (diff),
        .count_o (pop_cnt)
    );

    // One guard bit catches the carry so the counter pins at all-ones instead of wrapping.
    assign sum     = {1'b0, err_cnt_q} + SUM_W'(pop_cnt);
    assign cnt_sat = sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state_q     <= SEARCH;
            seed_pend_q <= 1'b1;
            ref_q       <= '0;
            match_q     <= '0;
            loss_q      <= '0;
            err_q       <= 1'b0;
            err_cnt_q   <= '0;
            poly_q      <= '0;
            len_q       <= '0;
            shift_q     <= '0;
        end else begin
            state_q     <= state_d;
            seed_pend_q <= seed_pend_d;
            ref_q       <= ref_d;
            match_q     <= match_d;
            loss_q      <= loss_d;
            err_q       <= err_d;
            err_cnt_q   <= err_cnt_d;
            poly_q      <= poly_d;
            len_q       <= len_d;
            shift_q     <= shift_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        seed_pend_d = seed_pend_q;
        ref_d       = ref_q;
        match_d     = match_q;
        loss_d      = loss_q;
        err_d       = err_q;
        err_cnt_d   = err_cnt_q;
        poly_d      = poly_q;
        len_d       = len_q;
        shift_d     = shift_q;

        if (bus.LOAD_I) begin
            // A word arriving alongside LOAD is dropped; the search restarts clean.
            poly_d      = bus.POLY_I;
            len_d       = bus.LEN_I;
            shift_d     = bus.SHIFT_I;
            state_d     = SEARCH;
            seed_pend_d = 1'b1;
            match_d     = '0;
            loss_d      = '0;
            err_d       = 1'b0;
            err_cnt_d   = '0;
        end else if (bus.EN_I) begin
            case (state_q)
                SEARCH: begin
                    ref_d = bus.DATA_I;
                    if (seed_pend_q) begin
                        seed_pend_d = 1'b0;
                        match_d     = '0;
                    end else if (diff == '0) begin
                        if (match_q == MATCH_W'(LOCK_THR - 1)) begin
                            state_d = LOCKED;
                            match_d = '0;
                            loss_d  = '0;
                        end else begin
                            match_d = match_q + MATCH_W'(1);
                        end
                    end else begin
                        match_d = '0;
                    end
                end
                LOCKED: begin
                    ref_d     = pred;
                    err_d     = |diff;
                    err_cnt_d = cnt_sat;
                    if (|diff) begin
                        if (loss_q == LOSS_W'(LOSS_THR - 1)) begin
                            state_d     = SEARCH;
                            seed_pend_d = 1'b1;
                            loss_d      = '0;
                        end else begin
                            loss_d = loss_q + LOSS_W'(1);
                        end
                    end else begin
                        loss_d = '0;
                    end
                end
                default: begin
                    state_d     = SEARCH;
                    seed_pend_d = 1'b1;
                end
            endcase
        end
    end

    assign bus.LOCK_O    = (state_q == LOCKED);
    assign bus.ERR_O     = err_q;
    assign bus.ERR_CNT_O = err_cnt_q;
    assign bus.STATE_O   = state_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Scoreboarded bench for prbs_checker: each driven word queues its expected
// {LOCK_O, ERR_O, ERR_CNT_O}, popped one cycle later when the checker updates.
module tb_prbs_checker;
    import prbs_pkg::*;

    localparam int W     = 8;
    localparam int CW    = 4;
    localparam int EXP_W = 2 + CW;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    prbs_checker_if #(.WIDTH(W), .CNT_W(CW)) bus_if ();

    prbs_checker #(
        .WIDTH    (W),
        .LOCK_THR (4),
        .LOSS_THR (3),
        .CNT_W    (CW)
    ) dut (
        .CLK_I (clk),
        .RST_I (rst),
        .bus   (bus_if)
    );

    int checks   = 0;
    int failures = 0;
    logic [EXP_W-1:0] exp_q[$];
    logic [EXP_W-1:0] mon_e;
    logic [W-1:0]     gen;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference stream for POLY=81, LEN=7: feedback is bit0 ^ bit7.
    function automatic logic [W-1:0] tb_step(input logic [W-1:0] x, input int n);
        logic [W-1:0] y;
        y = x;
        for (int k = 0; k < n; k++) y = {y[W-2:0], y[0] ^ y[W-1]};
        return y;
    endfunction

    task automatic send(input logic [W-1:0] d, input logic el, input logic ee,
                        input logic [CW-1:0] ec);
        @(negedge clk);
        bus_if.LOAD_I = 1'b0;
        bus_if.EN_I   = 1'b1;
        bus_if.DATA_I = d;
        exp_q.push_back({el, ee, ec});
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus_if.EN_I = 1'b0;
        end
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_lock"}, 32'(bus_if.LOCK_O), 32'(0));
        check_eq({tag, "_err"}, 32'(bus_if.ERR_O), 32'(0));
        check_eq({tag, "_cnt"}, 32'(bus_if.ERR_CNT_O), 32'(0));
    endtask

    task automatic load_cfg(input logic [W-1:0] p, input logic [W-1:0] l, input logic [W-1:0] s);
        @(negedge clk);
        bus_if.LOAD_I  = 1'b1;
        bus_if.EN_I    = 1'b0;
        bus_if.POLY_I  = p;
        bus_if.LEN_I   = l;
        bus_if.SHIFT_I = s;
        @(negedge clk);
        bus_if.LOAD_I = 1'b0;
        check_zero("load");
    endtask

    // Seed with gen, then four consistent words; lock expected after the fifth.
    task automatic acquire(input int sh, input logic ee, input logic [CW-1:0] ec, input bit gap);
        send(gen, 1'b0, ee, ec);
        for (int k = 1; k <= 4; k++) begin
            if (gap) idle(1);
            gen = tb_step(gen, sh);
            send(gen, (k == 4), ee, ec);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            if (bus_if.EN_I && !bus_if.LOAD_I && !rst) begin
                @(negedge clk);
                if (exp_q.size() == 0) begin
                    check_eq("sb_underflow", 32'(exp_q.size()), 32'(1));
                end else begin
                    mon_e = exp_q.pop_front();
                    check_eq("lock", 32'(bus_if.LOCK_O), 32'(mon_e[EXP_W-1]));
                    check_eq("err", 32'(bus_if.ERR_O), 32'(mon_e[EXP_W-2]));
                    check_eq("cnt", 32'(bus_if.ERR_CNT_O), 32'(mon_e[CW-1:0]));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        rst            = 1'b1;
        bus_if.LOAD_I  = 1'b0;
        bus_if.EN_I    = 1'b0;
        bus_if.POLY_I  = '0;
        bus_if.LEN_I   = '0;
        bus_if.SHIFT_I = '0;
        bus_if.DATA_I  = '0;
        repeat (3) @(negedge clk);
        check_zero("rst");
        check_eq("rst_state", 32'(bus_if.STATE_O), 32'(SEARCH));
        rst = 1'b0;
        @(negedge clk);
        check_zero("post_rst");

        // Reset configuration is all zero, so SHIFT=0: a constant stream locks.
        for (int i = 0; i < 5; i++) send(8'h5A, (i == 4), 1'b0, 4'd0);
        idle(2);

        // Acquire, then a single corrupted word (3A for 3F: two bit errors).
        load_cfg(8'h81, 8'd7, 8'd1);
        gen = 8'h01;
        acquire(1, 1'b0, 4'd0, 1'b0);
        gen = tb_step(gen, 1);
        send(8'h3A, 1'b1, 1'b1, 4'd2);
        gen = tb_step(gen, 1);
        send(gen, 1'b1, 1'b0, 4'd2);
        idle(2);

        // Loss after three bad words, then relock on the clean stream.
        load_cfg(8'h81, 8'd7, 8'd1);
        gen = 8'h01;
        acquire(1, 1'b0, 4'd0, 1'b0);
        gen = tb_step(gen, 1);
        send(gen ^ 8'h01, 1'b1, 1'b1, 4'd1);
        gen = tb_step(gen, 1);
        send(gen ^ 8'h01, 1'b1, 1'b1, 4'd2);
        gen = tb_step(gen, 1);
        send(gen ^ 8'h01, 1'b0, 1'b1, 4'd3);
        gen = tb_step(gen, 1);
        acquire(1, 1'b1, 4'd3, 1'b0);
        gen = tb_step(gen, 1);
        send(gen, 1'b1, 1'b0, 4'd3);
        idle(2);

        // Gapped EN: lock timing counts EN words only.
        load_cfg(8'h81, 8'd7, 8'd1);
        gen = 8'h01;
        acquire(1, 1'b0, 4'd0, 1'b1);
        idle(2);

        // SHIFT=2: 01,07,1F,7F,FE.
        load_cfg(8'h81, 8'd7, 8'd2);
        gen = 8'h01;
        acquire(2, 1'b0, 4'd0, 1'b0);
        idle(2);

        // SHIFT=9 clamps to 8 steps per word.
        load_cfg(8'h81, 8'd7, 8'd9);
        gen = 8'h01;
        acquire(8, 1'b0, 4'd0, 1'b0);
        idle(2);

        // Saturation: 8-bit errors on alternate words keep lock and pin the counter.
        load_cfg(8'h81, 8'd7, 8'd1);
        gen = 8'h01;
        acquire(1, 1'b0, 4'd0, 1'b0);
        gen = tb_step(gen, 1); send(gen ^ 8'hFF, 1'b1, 1'b1, 4'd8);
        gen = tb_step(gen, 1); send(gen, 1'b1, 1'b0, 4'd8);
        gen = tb_step(gen, 1); send(gen ^ 8'hFF, 1'b1, 1'b1, 4'd15);
        gen = tb_step(gen, 1); send(gen, 1'b1, 1'b0, 4'd15);
        gen = tb_step(gen, 1); send(gen ^ 8'hFF, 1'b1, 1'b1, 4'd15);
        gen = tb_step(gen, 1); send(gen, 1'b1, 1'b0, 4'd15);

        // LOAD with EN: 01 is discarded, so 03 seeds and lock comes at 3F, not 1F.
        @(negedge clk);
        bus_if.LOAD_I  = 1'b1;
        bus_if.EN_I    = 1'b1;
        bus_if.DATA_I  = 8'h01;
        bus_if.POLY_I  = 8'h81;
        bus_if.LEN_I   = 8'd7;
        bus_if.SHIFT_I = 8'd1;
        @(negedge clk);
        bus_if.LOAD_I = 1'b0;
        bus_if.EN_I   = 1'b0;
        check_zero("load_en");
        gen = 8'h03;
        acquire(1, 1'b0, 4'd0, 1'b0);

        // Reset mid-lock, asserted between edges.
        gen = tb_step(gen, 1); send(gen ^ 8'h10, 1'b1, 1'b1, 4'd1);
        gen = tb_step(gen, 1); send(gen, 1'b1, 1'b0, 4'd1);
        idle(2);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check_zero("async_rst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_zero("rst_release");
        load_cfg(8'h81, 8'd7, 8'd1);
        gen = 8'hC3;
        acquire(1, 1'b0, 4'd0, 1'b0);
        idle(3);
        check_eq("drain", 32'(exp_q.size()), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
